tick_sched_ctrl: RTL and testbench

//  Run-time controller for the mod-N divider datapath. Holds the active divide ratio and

---
 rtl/tick_sched_ctrl_if.sv | 21 ++
 rtl/tick_sched_ctrl.sv | 133 +++++++++++++
 tb/tb_tick_sched_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_sched_ctrl_if.sv
// tick_sched_ctrl_if: divide-ratio config handshake.
// master offers cfg_div, slave accepts on valid && ready.
interface tick_sched_ctrl_if #(
  parameter int N = 5
) ();
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: run-time controller for the mod-N divider.
// Defers ratio changes to period boundaries; burst/continuous.
module tick_sched_ctrl #(
  parameter int N         = 5,
  parameter int M_DEFAULT = 29,
  parameter int B         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tick_sched_ctrl_if.slave  cfg,
  input  logic              start,
  input  logic [B-1:0]      start_burst,
  input  logic              stop,
  output logic              busy,
  output logic              tick,
  output logic              out,
  output logic              done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] DIV_RST = M_DEFAULT[N-1:0];
  localparam logic [N-1:0] N_ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] N_TWO   = {{(N-2){1'b0}}, 2'b10};
  localparam logic [B-1:0] B_ONE   = {{(B-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic [N-1:0] r_div;
  logic [N-1:0] r_sh;
  logic [N-1:0] r_cnt;
  logic [B-1:0] r_left;
  logic         r_pend;
  logic         r_rdy;
  logic         r_busy;
  logic         r_tick;
  logic         r_out;
  logic         r_done;

  logic [N-1:0] w_eff;
  logic         w_acc;
  logic         w_term;
  logic         w_last;

  // ratios 0 and 1 cannot make a period, clamp them to 2
  always_comb begin
    w_eff  = (cfg.cfg_div < N_TWO) ? N_TWO : cfg.cfg_div;
    w_acc  = cfg.cfg_valid && r_rdy;
    w_term = (r_cnt >= (r_div - N_ONE));
    w_last = (r_left == B_ONE);
  end

  // controller FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= DIV_RST;
      r_sh    <= DIV_RST;
      r_cnt   <= '0;
      r_left  <= '0;
      r_pend  <= 1'b0;
      r_rdy   <= 1'b1;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
      r_out   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) r_div <= w_eff;
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_out   <= 1'b0;
            r_left  <= start_burst;
          end
        end
        S_RUN: begin
          priority case (1'b1)
            stop: begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_out   <= 1'b0;
              r_busy  <= 1'b0;
              r_pend  <= 1'b0;
              r_rdy   <= 1'b1;
              if (w_acc)       r_div <= w_eff;
              else if (r_pend) r_div <= r_sh;
            end
            w_term: begin
              r_cnt  <= '0;
              r_out  <= ~r_out;
              r_tick <= 1'b1;
              r_pend <= 1'b0;
              r_rdy  <= 1'b1;
              if (w_acc)       r_div <= w_eff;
              else if (r_pend) r_div <= r_sh;
              if (r_left != '0) begin
                r_left <= r_left - B_ONE;
                if (w_last) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              end
            end
            default: begin
              r_cnt <= r_cnt + N_ONE;
              if (w_acc) begin
                r_sh   <= w_eff;
                r_pend <= 1'b1;
                r_rdy  <= 1'b0;
              end
            end
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready = r_rdy;
  assign busy          = r_busy;
  assign tick          = r_tick;
  assign out           = r_out;
  assign done          = r_done;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// tb_tick_sched_ctrl: directed and random stimulus against
// a period-level reference model of the tick scheduler.
module tb_tick_sched_ctrl;

  localparam int N = 5;
  localparam int B = 8;
  localparam int M_DEFAULT = 29;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [B-1:0] start_burst;
  logic         stop;
  logic         busy;
  logic         tick;
  logic         out;
  logic         done;

  tick_sched_ctrl_if #(.N(N)) cfg_if ();

  tick_sched_ctrl #(
    .N(N), .M_DEFAULT(M_DEFAULT), .B(B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if.slave),
    .start       (start),
    .start_burst (start_burst),
    .stop        (stop),
    .busy        (busy),
    .tick        (tick),
    .out         (out),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int n_ticks;

  // reference model: a run is a sequence of periods, each
  // lasting m_period cycles; m_next is a deferred ratio
  bit m_run;
  int m_elapsed;
  int m_period;
  int m_next;
  int m_left;
  bit m_out;
  bit m_tick;
  bit m_done;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  tag, got, exp, $time);
  endtask

  function automatic void m_reset();
    m_run = 0; m_elapsed = 0; m_period = M_DEFAULT;
    m_next = -1; m_left = 0; m_out = 0;
    m_tick = 0; m_done = 0;
  endfunction

  function automatic void m_step(bit v, int d, bit st,
                                 int sb, bit sp);
    bit acc;
    int eff;
    acc = v && (m_next < 0);
    eff = (d < 2) ? 2 : d;
    m_tick = 0;
    m_done = 0;
    if (!m_run) begin
      if (acc) m_period = eff;
      if (st) begin
        m_run = 1; m_elapsed = 0; m_out = 0; m_left = sb;
      end
    end else if (sp) begin
      m_run = 0; m_elapsed = 0; m_out = 0;
      if (acc) m_period = eff;
      else if (m_next >= 0) m_period = m_next;
      m_next = -1;
    end else begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_elapsed = 0;
        m_tick = 1;
        m_out = !m_out;
        if (acc) m_period = eff;
        else if (m_next >= 0) m_period = m_next;
        m_next = -1;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1;
            m_run = 0;
          end
        end
      end else if (acc) begin
        m_next = eff;
      end
    end
  endfunction

  function automatic logic [4:0] m_vec();
    return {m_tick, m_out, m_run, m_done, m_next < 0};
  endfunction

  function automatic logic [4:0] d_vec();
    return {tick, out, busy, done, cfg_if.cfg_ready};
  endfunction

  task automatic cyc(input bit v, input int d, input bit st,
                     input int sb, input bit sp,
                     input string tag);
    @(negedge clk);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div = d[N-1:0];
    start = st;
    start_burst = sb[B-1:0];
    stop = sp;
    @(posedge clk);
    m_step(v, d, st, sb, sp);
    #1;
    chk(tag, {27'd0, d_vec()}, {27'd0, m_vec()});
    if (tick) n_ticks++;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_async", {27'd0, d_vec()}, 32'h1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_ticks = 0;
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div = '0;
    start = 1'b0;
    start_burst = '0;
    stop = 1'b0;
    m_reset();
    #12;
    chk("rst_state", {27'd0, d_vec()}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, "post_rst");

    // default ratio, continuous
    cyc(0, 0, 1, 0, 0, "t1_start");
    n_ticks = 0;
    idle(60, "t1_run");
    chk("t1_ticks", n_ticks, 2);
    cyc(0, 0, 0, 0, 1, "t1_stop");

    // ratio 4 from idle, continuous
    cyc(1, 4, 0, 0, 0, "t2_cfg");
    cyc(0, 0, 1, 0, 0, "t2_start");
    n_ticks = 0;
    idle(12, "t2_run");
    chk("t2_ticks", n_ticks, 3);
    cyc(0, 0, 0, 0, 1, "t2_stop");

    // deferred change 10 -> 3 mid-period
    cyc(1, 10, 1, 0, 0, "t3_start");
    idle(2, "t3_wait");
    cyc(1, 3, 0, 0, 0, "t3_cfg");
    n_ticks = 0;
    idle(13, "t3_run");
    chk("t3_ticks", n_ticks, 3);
    cyc(0, 0, 0, 0, 1, "t3_stop");

    // burst of 3 at ratio 5
    cyc(1, 5, 1, 3, 0, "t4_start");
    n_ticks = 0;
    idle(22, "t4_run");
    chk("t4_ticks", n_ticks, 3);

    // stop on terminal with pending ratio 7
    cyc(1, 6, 1, 0, 0, "t5_start");
    cyc(0, 0, 0, 0, 0, "t5_w");
    cyc(1, 7, 0, 0, 0, "t5_cfg");
    idle(3, "t5_w");
    cyc(0, 0, 0, 0, 1, "t5_stop");
    cyc(0, 0, 1, 1, 0, "t5_restart");
    n_ticks = 0;
    idle(7, "t5_run");
    chk("t5_ticks", n_ticks, 1);

    // saturation and async reset mid-burst
    cyc(1, 0, 1, 4, 0, "t6_start0");
    idle(3, "t6_run");
    do_reset();
    cyc(1, 1, 1, 3, 0, "t6_start1");
    idle(7, "t6_run");
    do_reset();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit v, st, sp;
      int d, sb;
      v  = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 7) == 0) ?
           $urandom_range(0, 31) : $urandom_range(0, 8);
      st = ($urandom_range(0, 7) == 0);
      sb = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
      sp = ($urandom_range(0, 39) == 0);
      cyc(v, d, st, sb, sp, "rand");
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
